tx_frame_arbiter: RTL and testbench

- Shares the MAC engine's single 64-bit AXI-stream TX input (s_tx_axis_*) between NUM_PORTS frame sources.
- Arbitration is round-robin at frame granularity: once a port is granted, its frame passes intact up to tlast.
- A MAX_BEATS guard truncates runaway frames. After truncation the block drains the rest of that frame so the MAC never sees a frame that does not end.
- Sits directly in front of mac_engine TX; its master port wires to s_tx_axis_*.

---
 rtl/tx_frame_arbiter.sv | 124 ++++++++++++
 tb/tb_tx_frame_arbiter.sv | 305 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/tx_frame_arbiter.sv
// tx_frame_arbiter: round-robin, frame-granular arbiter sharing one AXI-stream TX input among several sources
module tx_frame_arbiter #(
  parameter int DATA_WIDTH = 64,
  parameter int KEEP_WIDTH = 8,
  parameter int NUM_PORTS  = 4,
  parameter int MAX_BEATS  = 256
) (
  input  logic                             clk,
  input  logic                             reset,
  input  logic [NUM_PORTS*DATA_WIDTH-1:0]  s_axis_tdata,
  input  logic [NUM_PORTS*KEEP_WIDTH-1:0]  s_axis_tkeep,
  input  logic [NUM_PORTS-1:0]             s_axis_tvalid,
  input  logic [NUM_PORTS-1:0]             s_axis_tlast,
  output logic [NUM_PORTS-1:0]             s_axis_tready,
  output logic [DATA_WIDTH-1:0]            m_axis_tdata,
  output logic [KEEP_WIDTH-1:0]            m_axis_tkeep,
  output logic                             m_axis_tvalid,
  output logic                             m_axis_tlast,
  input  logic                             m_axis_tready,
  output logic [NUM_PORTS-1:0]             grant,
  output logic                             frame_done,
  output logic [NUM_PORTS-1:0]             trunc_err
);
  localparam int IW = NUM_PORTS > 1 ? $clog2(NUM_PORTS) : 1;
  localparam int CW = $clog2(MAX_BEATS) + 1;
  typedef enum logic [1:0] {IDLE, FWD, DRAIN} state_t;
  state_t state_q, state_d;
  logic [NUM_PORTS-1:0] grant_q, grant_d, trunc_err_q, trunc_err_d;
  logic [IW-1:0] last_ptr_q, last_ptr_d, pick;
  logic [CW-1:0] beat_cnt_q, beat_cnt_d;
  logic frame_done_q, frame_done_d, found;
  logic [DATA_WIDTH-1:0] g_data;
  logic [KEEP_WIDTH-1:0] g_keep;
  logic g_valid, g_last, at_max;
  // last_ptr doubles as the index of the owning port while a grant is held
  assign g_data  = s_axis_tdata[last_ptr_q*DATA_WIDTH +: DATA_WIDTH];
  assign g_keep  = s_axis_tkeep[last_ptr_q*KEEP_WIDTH +: KEEP_WIDTH];
  assign g_valid = s_axis_tvalid[last_ptr_q];
  assign g_last  = s_axis_tlast[last_ptr_q];
  assign at_max  = beat_cnt_q == CW'(MAX_BEATS - 1);
  assign grant      = grant_q;
  assign frame_done = frame_done_q;
  assign trunc_err  = trunc_err_q;
  // first requesting port searching upward from the one after the last winner
  always_comb begin
    pick  = last_ptr_q;
    found = 1'b0;
    for (int k = 1; k <= NUM_PORTS; k++) begin
      if (!found && s_axis_tvalid[IW'((int'(last_ptr_q) + k) % NUM_PORTS)]) begin
        found = 1'b1;
        pick  = IW'((int'(last_ptr_q) + k) % NUM_PORTS);
      end
    end
  end
  // next state and zero-latency pass-through of the granted port
  always_comb begin
    state_d       = state_q;
    grant_d       = grant_q;
    last_ptr_d    = last_ptr_q;
    beat_cnt_d    = beat_cnt_q;
    frame_done_d  = 1'b0;
    trunc_err_d   = '0;
    s_axis_tready = '0;
    m_axis_tdata  = '0;
    m_axis_tkeep  = '0;
    m_axis_tvalid = 1'b0;
    m_axis_tlast  = 1'b0;
    case (state_q)
      IDLE: begin
        if (found) begin
          state_d    = FWD;
          grant_d    = NUM_PORTS'(1) << pick;
          last_ptr_d = pick;
          beat_cnt_d = '0;
        end
      end
      FWD: begin
        m_axis_tdata  = g_data;
        m_axis_tkeep  = g_keep;
        m_axis_tvalid = g_valid;
        m_axis_tlast  = g_last | at_max;
        s_axis_tready[last_ptr_q] = m_axis_tready;
        if (g_valid && m_axis_tready) begin
          beat_cnt_d = beat_cnt_q + CW'(1);
          if (g_last) begin
            frame_done_d = 1'b1;
            grant_d      = '0;
            state_d      = IDLE;
          end else if (at_max) begin
            frame_done_d = 1'b1;
            trunc_err_d[last_ptr_q] = 1'b1;
            state_d      = DRAIN;
          end
        end
      end
      DRAIN: begin
        s_axis_tready[last_ptr_q] = 1'b1;
        if (g_valid && g_last) begin
          grant_d = '0;
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end
  // state, grant and pulse registers; reset abandons any frame in flight
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q      <= IDLE;
      grant_q      <= '0;
      last_ptr_q   <= IW'(NUM_PORTS - 1);
      beat_cnt_q   <= '0;
      frame_done_q <= 1'b0;
      trunc_err_q  <= '0;
    end else begin
      state_q      <= state_d;
      grant_q      <= grant_d;
      last_ptr_q   <= last_ptr_d;
      beat_cnt_q   <= beat_cnt_d;
      frame_done_q <= frame_done_d;
      trunc_err_q  <= trunc_err_d;
    end
  end
endmodule

// File: tb/tb_tx_frame_arbiter.sv
// tb_tx_frame_arbiter: randomized frame sources and MAC backpressure checked against a transaction-level model
module tb_tx_frame_arbiter;
  localparam int NP = 4, DW = 64, KW = 8, MB = 4;
  typedef struct packed {
    logic [DW-1:0] data;
    logic [KW-1:0] keep;
    logic          last;
    logic          trunc;
  } beat_t;
  logic clk = 1'b0, reset = 1'b0, m_tready = 1'b0;
  logic [NP*DW-1:0] s_tdata = '0;
  logic [NP*KW-1:0] s_tkeep = '0;
  logic [NP-1:0] s_tvalid = '0, s_tlast = '0, s_tready, grant, trunc_err;
  logic [DW-1:0] m_tdata;
  logic [KW-1:0] m_tkeep;
  logic m_tvalid, m_tlast, frame_done;
  beat_t src_q[NP][$];
  beat_t exp_q[NP][$];
  bit rdy_q[$];
  int grant_log[$];
  int n_chk = 0, n_fail = 0, gap_pct = 0, rdy_pct = 100, last_ptr = NP - 1;
  int n_done = 0, n_trunc = 0, n_frames = 0, n_long = 0;
  logic [NP-1:0] hs = '0, prev_grant = '0, prev_vld = '0, exp_trunc = '0, trunc_seen = '0;
  logic exp_done = 1'b0, drain = 1'b0, end_pending = 1'b0;

  tx_frame_arbiter #(.DATA_WIDTH(DW), .KEEP_WIDTH(KW), .NUM_PORTS(NP), .MAX_BEATS(MB)) dut (
    .clk(clk), .reset(reset),
    .s_axis_tdata(s_tdata), .s_axis_tkeep(s_tkeep), .s_axis_tvalid(s_tvalid),
    .s_axis_tlast(s_tlast), .s_axis_tready(s_tready),
    .m_axis_tdata(m_tdata), .m_axis_tkeep(m_tkeep), .m_axis_tvalid(m_tvalid),
    .m_axis_tlast(m_tlast), .m_axis_tready(m_tready),
    .grant(grant), .frame_done(frame_done), .trunc_err(trunc_err)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] want);
    n_chk++;
    if (got !== want) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, want);
    end
  endtask

  // Source queue gets the raw frame; expected queue gets what the MAC must see:
  // at most MB beats, with tlast forced on beat MB when the frame is longer.
  task automatic add_frame(input int p, input int n, input logic [DW-1:0] base, input logic [KW-1:0] lkeep);
    beat_t b;
    for (int i = 0; i < n; i++) begin
      b.data  = base + DW'(i);
      b.keep  = (i == n - 1) ? lkeep : '1;
      b.last  = (i == n - 1);
      b.trunc = 1'b0;
      src_q[p].push_back(b);
      if (i < MB) begin
        b.last  = (i == n - 1) || (i == MB - 1);
        b.trunc = (i == MB - 1) && (n > MB);
        exp_q[p].push_back(b);
      end
    end
    n_frames++;
    if (n > MB) n_long++;
  endtask

  function automatic bit all_empty();
    for (int p = 0; p < NP; p++) if (src_q[p].size() != 0 || exp_q[p].size() != 0) return 1'b0;
    return 1'b1;
  endfunction

  function automatic int log_code();
    int c = 0;
    foreach (grant_log[i]) c = c * 10 + grant_log[i] + 1;
    return c;
  endfunction

  task automatic sample();
    int g;
    logic [NP-1:0] oh, want;
    logic end_now;
    beat_t e;
    g = -1;
    for (int p = 0; p < NP; p++) if (grant[p]) g = p;
    oh = (g >= 0) ? NP'(1) << g : '0;
    if (frame_done) n_done++;
    trunc_seen |= trunc_err;
    if (trunc_err != 0) n_trunc++;
    chk("frame_done", frame_done, exp_done);
    chk("trunc_err", trunc_err, exp_trunc);
    exp_done  = 1'b0;
    exp_trunc = '0;
    end_now   = 1'b0;
    if (prev_grant == 0) begin
      want = '0;
      for (int k = 1; k <= NP; k++)
        if (want == 0 && prev_vld[(last_ptr + k) % NP]) want = NP'(1) << ((last_ptr + k) % NP);
      chk("grant_rr", grant, want);
      if (g >= 0) begin
        last_ptr = g;
        grant_log.push_back(g);
        drain = 1'b0;
      end
    end else chk("grant_hold", grant, end_pending ? '0 : prev_grant);
    if (g < 0) begin
      chk("m_tvalid_idle", m_tvalid, 0);
      chk("tready_idle", s_tready, 0);
    end else if (drain) begin
      chk("m_tvalid_drain", m_tvalid, 0);
      chk("tready_drain", s_tready, oh);
      if (s_tvalid[g] && s_tlast[g]) begin
        end_now = 1'b1;
        drain = 1'b0;
      end
    end else begin
      chk("m_tvalid_fwd", m_tvalid, s_tvalid[g]);
      chk("tready_fwd", s_tready, m_tready ? oh : '0);
      if (m_tvalid && m_tready) begin
        if (exp_q[g].size() == 0) chk("extra_beat", 1, 0);
        else begin
          e = exp_q[g].pop_front();
          chk("tdata", m_tdata, e.data);
          chk("tkeep", m_tkeep, e.keep);
          chk("tlast", m_tlast, e.last);
          if (e.last) begin
            exp_done = 1'b1;
            end_now  = !e.trunc;
            if (e.trunc) begin
              exp_trunc = oh;
              drain = 1'b1;
            end
          end
        end
      end
    end
    for (int p = 0; p < NP; p++) begin
      hs[p] = s_tvalid[p] & s_tready[p];
      if (hs[p] && src_q[p].size() > 0) void'(src_q[p].pop_front());
    end
    prev_grant  = grant;
    prev_vld    = s_tvalid;
    end_pending = end_now;
  endtask

  task automatic drive();
    for (int p = 0; p < NP; p++) begin
      if (!s_tvalid[p] || hs[p]) s_tvalid[p] = (src_q[p].size() > 0) && ($urandom_range(99) >= gap_pct);
      if (src_q[p].size() > 0) begin
        s_tdata[p*DW +: DW] = src_q[p][0].data;
        s_tkeep[p*KW +: KW] = src_q[p][0].keep;
        s_tlast[p]          = src_q[p][0].last;
      end else begin
        s_tdata[p*DW +: DW] = '0;
        s_tkeep[p*KW +: KW] = '0;
        s_tlast[p]          = 1'b0;
      end
    end
    m_tready = (rdy_q.size() > 0) ? rdy_q.pop_front() : ($urandom_range(99) < rdy_pct);
    hs = '0;
  endtask

  task automatic cycle();
    @(negedge clk);
    sample();
    @(posedge clk);
    #1;
    drive();
  endtask

  task automatic run_idle(input int budget);
    int c = 0;
    while (c < budget && !(all_empty() && grant == 0 && !drain)) begin
      cycle();
      c++;
    end
    chk("idle_timeout", c < budget, 1);
    repeat (3) cycle();
  endtask

  task automatic do_reset();
    reset = 1'b1;
    s_tvalid = '0;
    s_tlast = '0;
    m_tready = 1'b0;
    for (int p = 0; p < NP; p++) begin
      src_q[p].delete();
      exp_q[p].delete();
    end
    rdy_q.delete();
    grant_log.delete();
    last_ptr = NP - 1;
    prev_grant = '0;
    prev_vld = '0;
    exp_done = 1'b0;
    exp_trunc = '0;
    drain = 1'b0;
    end_pending = 1'b0;
    hs = '0;
    repeat (2) @(posedge clk);
    #1;
    reset = 1'b0;
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int d0, t0, f0, l0;
    #1 reset = 1'b1;
    #1;
    chk("rst_grant", grant, 0);
    chk("rst_m_tvalid", m_tvalid, 0);
    chk("rst_m_tlast", m_tlast, 0);
    chk("rst_m_tdata", m_tdata, 0);
    chk("rst_m_tkeep", m_tkeep, 0);
    chk("rst_tready", s_tready, 0);
    chk("rst_frame_done", frame_done, 0);
    chk("rst_trunc_err", trunc_err, 0);
    do_reset();
    // single 3-beat frame from port 0
    add_frame(0, 3, 64'hA0, 8'h0F);
    d0 = n_done;
    run_idle(50);
    chk("t1_done", n_done - d0, 1);
    chk("t1_order", log_code(), 1);
    // contention after reset: ports 0,1,3 at once
    do_reset();
    add_frame(0, 2, 64'h100, 8'hFF);
    add_frame(1, 2, 64'h200, 8'h03);
    add_frame(3, 2, 64'h300, 8'h01);
    d0 = n_done;
    run_idle(60);
    chk("t2_order", log_code(), 124);
    chk("t2_done", n_done - d0, 3);
    // backpressure on a 4-beat frame from port 2
    grant_log.delete();
    rdy_q = '{1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1};
    add_frame(2, 4, 64'h400, 8'h7F);
    d0 = n_done;
    t0 = n_trunc;
    run_idle(60);
    chk("t3_order", log_code(), 3);
    chk("t3_done", n_done - d0, 1);
    chk("t3_no_trunc", n_trunc - t0, 0);
    // truncation of a 6-beat frame from port 1, then port 2 follows
    grant_log.delete();
    trunc_seen = '0;
    add_frame(1, 6, 64'h500, 8'h3F);
    add_frame(2, 2, 64'h600, 8'hFF);
    d0 = n_done;
    t0 = n_trunc;
    run_idle(80);
    chk("t4_order", log_code(), 23);
    chk("t4_trunc_cnt", n_trunc - t0, 1);
    chk("t4_trunc_port", trunc_seen, 4'b0010);
    chk("t4_done", n_done - d0, 2);
    // fairness: port 2 arrives while port 0 streams back-to-back frames
    grant_log.delete();
    add_frame(0, 3, 64'h700, 8'hFF);
    add_frame(0, 3, 64'h710, 8'hFF);
    repeat (3) cycle();
    add_frame(2, 2, 64'h800, 8'h0F);
    run_idle(80);
    chk("t5_order", log_code(), 131);
    // asynchronous reset in the middle of a port 3 frame
    grant_log.delete();
    add_frame(3, 4, 64'h900, 8'hFF);
    for (int i = 0; i < 10 && !grant[3]; i++) cycle();
    cycle();
    #2;
    chk("t6_pre_valid", m_tvalid, 1);
    reset = 1'b1;
    #1;
    chk("t6_async_tvalid", m_tvalid, 0);
    chk("t6_async_grant", grant, 0);
    chk("t6_async_tready", s_tready, 0);
    chk("t6_async_tdata", m_tdata, 0);
    do_reset();
    add_frame(0, 2, 64'hA00, 8'hFF);
    add_frame(3, 2, 64'hB00, 8'hFF);
    run_idle(60);
    chk("t6_order", log_code(), 14);
    // random traffic with source gaps and MAC backpressure
    gap_pct = 25;
    rdy_pct = 70;
    d0 = n_done;
    t0 = n_trunc;
    f0 = n_frames;
    l0 = n_long;
    for (int i = 0; i < 800; i++) begin
      if ($urandom_range(3) == 0) begin
        int p = $urandom_range(NP - 1);
        if (src_q[p].size() < 12)
          add_frame(p, $urandom_range(1, 6), {$urandom(), $urandom()}, KW'($urandom_range(1, 255)));
      end
      cycle();
    end
    run_idle(3000);
    chk("rand_done", n_done - d0, n_frames - f0);
    chk("rand_trunc", n_trunc - t0, n_long - l0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
